// File: rtl/fp_pkg.sv
// Shared single-precision float datapath constants, FSM state encoding and mantissa type.
// Latency: none (declarations only).
// Backpressure: not applicable.
package fp_pkg;

    localparam int EXP_W     = 8;
    localparam int MANT_W    = 23;
    localparam int SHIFT_MAX = MANT_W + 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    // Mantissa with the hidden bit restored in the MSB.
    typedef logic [MANT_W:0] mant_h_t;

endpackage

// File: rtl/align_shift_step.sv
// One-bit logical right shift of a mantissa with sticky accumulation of the dropped LSB.
// Latency: combinational.
// Backpressure: none; the caller decides when the result is registered.
module align_shift_step #(
    parameter int W = 24
) (
    input  logic [W-1:0] mant_in,
    input  logic         sticky_in,
    output logic [W-1:0] mant_out,
    output logic         sticky_out
);

    // Zero-fill from the top; the bit falling off the bottom joins the sticky.
    assign mant_out   = {1'b0, mant_in[W-1:1]};
    assign sticky_out = sticky_in | mant_in[0];

endmodule

// File: rtl/align_exp_mant.sv
// Aligns two (exp, mant) operands to the larger exponent, shifting the smaller mantissa one bit per cycle.
// Latency: out_valid 2 + min(|exp_a - exp_b|, SHIFT_MAX) cycles after the accept edge.
// Backpressure: one operation in flight; in_ready only in IDLE, result held in DONE until out_ready.
module align_exp_mant #(
    parameter int EXP_W     = fp_pkg::EXP_W,
    parameter int MANT_W    = fp_pkg::MANT_W,
    parameter int SHIFT_MAX = fp_pkg::SHIFT_MAX
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [EXP_W-1:0]  exp_a,
    input  logic [MANT_W-1:0] mant_a,
    input  logic [EXP_W-1:0]  exp_b,
    input  logic [MANT_W-1:0] mant_b,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [EXP_W-1:0]  exp_out,
    output logic [MANT_W:0]   mant_big,
    output logic [MANT_W:0]   mant_small,
    output logic              sticky,
    output logic              swap
);

    import fp_pkg::*;

    localparam int CNT_W = $clog2(SHIFT_MAX + 1);

    state_e            state_q;
    state_e            state_d;
    logic              started_q;
    logic              out_valid_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              accept;
    logic              swap_d;
    logic [EXP_W:0]    diff;
    logic [MANT_W:0]   mant_a_h;
    logic [MANT_W:0]   mant_b_h;
    logic [MANT_W:0]   step_mant;
    logic              step_sticky;

    // Zero exponent means zero/denormal, so the hidden bit stays clear.
    assign mant_a_h = {(exp_a != '0), mant_a};
    assign mant_b_h = {(exp_b != '0), mant_b};

    // Difference is taken one bit wider than the exponent so it can never wrap.
    assign swap_d = (exp_b > exp_a);
    assign diff   = swap_d ? ({1'b0, exp_b} - {1'b0, exp_a})
                           : ({1'b0, exp_a} - {1'b0, exp_b});
    assign accept = in_valid & in_ready;

    align_shift_step #(.W(MANT_W + 1)) u_step (
        .mant_in    (mant_small),
        .sticky_in  (sticky),
        .mant_out   (step_mant),
        .sticky_out (step_sticky)
    );

    // State register; started_q keeps in_ready low until the first edge after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            started_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            started_q <= 1'b1;
        end
    end

    // Next-state: shift until the count drains, then hold the result until it is taken.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept)                     state_d = SHIFT;
            SHIFT:   if (cnt_q == '0)                state_d = DONE;
            DONE:    if (out_valid_q && out_ready)   state_d = IDLE;
            default:                                 state_d = IDLE;
        endcase
    end

    // Outputs decoded from state.
    always_comb begin
        in_ready  = started_q && (state_q == IDLE);
        out_valid = out_valid_q;
    end

    // out_valid is registered off DONE and drops on the handshake edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
        end else begin
            out_valid_q <= (state_q == DONE) && !(out_valid_q && out_ready);
        end
    end

    // Datapath: capture operands on accept, then one shift step per SHIFT cycle while cnt is nonzero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_out    <= '0;
            mant_big   <= '0;
            mant_small <= '0;
            sticky     <= 1'b0;
            swap       <= 1'b0;
            cnt_q      <= '0;
        end else if (accept) begin
            swap       <= swap_d;
            exp_out    <= swap_d ? exp_b    : exp_a;
            mant_big   <= swap_d ? mant_b_h : mant_a_h;
            mant_small <= swap_d ? mant_a_h : mant_b_h;
            sticky     <= 1'b0;
            cnt_q      <= (diff > (EXP_W + 1)'(SHIFT_MAX)) ? CNT_W'(SHIFT_MAX) : CNT_W'(diff);
        end else if ((state_q == SHIFT) && (cnt_q != '0)) begin
            mant_small <= step_mant;
            sticky     <= step_sticky;
            cnt_q      <= cnt_q - CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_align_exp_mant.sv
// Bench for align_exp_mant: directed cases plus random operand pairs against a one-shot shift model.
// Latency: measured per operation and compared with 2 + min(diff, 25).
// Backpressure: out_ready held low for a programmable number of cycles in DONE.
module tb_align_exp_mant;

    import fp_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  exp_a;
    logic [22:0] mant_a;
    logic [7:0]  exp_b;
    logic [22:0] mant_b;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  exp_out;
    logic [23:0] mant_big;
    logic [23:0] mant_small;
    logic        sticky;
    logic        swap;

    int n_checks = 0;
    int n_fail   = 0;

    align_exp_mant dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .exp_a      (exp_a),
        .mant_a     (mant_a),
        .exp_b      (exp_b),
        .mant_b     (mant_b),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .exp_out    (exp_out),
        .mant_big   (mant_big),
        .mant_small (mant_small),
        .sticky     (sticky),
        .swap       (swap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input longint obs, input longint exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp_v);
        end
    endtask

    task automatic check_idle_zero(input string tag);
        check({tag, "_in_ready"},   longint'(in_ready),   0);
        check({tag, "_out_valid"},  longint'(out_valid),  0);
        check({tag, "_exp_out"},    longint'(exp_out),    0);
        check({tag, "_mant_big"},   longint'(mant_big),   0);
        check({tag, "_mant_small"}, longint'(mant_small), 0);
        check({tag, "_sticky"},     longint'(sticky),     0);
        check({tag, "_swap"},       longint'(swap),       0);
    endtask

    // Drive one operand pair, wait for the result, hold it for 'hold' cycles, then complete the handshake.
    task automatic run_op(input int ea, input int ma, input int eb, input int mb, input int hold);
        mant_h_t ha, hb, hbig, hsml, exp_small;
        longint  lost;
        int      d, sh, lat, k;
        bit      sw;

        // Reference: restore hidden bits, pick the larger exponent, shift the smaller in one go.
        ha   = mant_h_t'(((ea != 0) ? 32'h80_0000 : 32'h0) | ma);
        hb   = mant_h_t'(((eb != 0) ? 32'h80_0000 : 32'h0) | mb);
        sw   = (eb > ea);
        d    = sw ? (eb - ea) : (ea - eb);
        sh   = (d > 25) ? 25 : d;
        hbig = sw ? hb : ha;
        hsml = sw ? ha : hb;
        exp_small = mant_h_t'(longint'(hsml) >> sh);
        lost      = longint'(hsml) & ((64'd1 << sh) - 1);

        @(negedge clk);
        in_valid = 1'b1;
        exp_a = 8'(ea); mant_a = 23'(ma);
        exp_b = 8'(eb); mant_b = 23'(mb);
        k = 0;
        while (!in_ready && k < 50) begin
            @(negedge clk);
            k++;
        end
        if (!in_ready) begin
            check("accept_timeout", 0, 1);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        @(negedge clk);
        check("busy_in_ready", longint'(in_ready), 0);
        // Operand changes while busy must not disturb the operation in flight.
        exp_a  = 8'($urandom);  mant_a = 23'($urandom);
        exp_b  = 8'($urandom);  mant_b = 23'($urandom);
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        in_valid = 1'b0;
        if (!out_valid) begin
            check("done_timeout", 0, 1);
            return;
        end
        check("latency",    lat, 2 + sh);
        check("exp_out",    longint'(exp_out),    sw ? eb : ea);
        check("mant_big",   longint'(mant_big),   longint'(hbig));
        check("mant_small", longint'(mant_small), longint'(exp_small));
        check("sticky",     longint'(sticky),     (lost != 0) ? 1 : 0);
        check("swap",       longint'(swap),       longint'(sw));
        check("done_in_ready", longint'(in_ready), 0);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("hold_valid",      longint'(out_valid),  1);
            check("hold_mant_small", longint'(mant_small), longint'(exp_small));
            check("hold_in_ready",   longint'(in_ready),   0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("post_hs_valid",    longint'(out_valid), 0);
        check("post_hs_in_ready", longint'(in_ready),  1);
    endtask

    initial begin
        int ea, eb, k;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        exp_a = '0; mant_a = '0; exp_b = '0; mant_b = '0;

        repeat (3) @(negedge clk);
        check_idle_zero("reset");
        rst_n = 1'b1;
        #1;
        check("release_in_ready", longint'(in_ready), 0);
        @(negedge clk);
        check("first_edge_in_ready", longint'(in_ready), 1);

        // Directed cases.
        run_op(127, 0,        126, 0,        0);
        run_op(130, 0,        130, 'h40_0000, 0);
        run_op(100, 1,        150, 0,        0);
        run_op(128, 0,        125, 7,        0);
        run_op(140, 'h12_3456, 135, 'h7F_FFFF, 10);
        run_op(0,   5,        3,   0,        0);
        run_op(0,   'h40_0000, 0,  1,        0);
        run_op(255, 'h7F_FFFF, 0,  'h7F_FFFF, 2);
        run_op(60,  'h55_5555, 85, 0,        0);
        run_op(10,  'h7F_FFFF, 34, 0,        0);

        // Reset during SHIFT: result dropped, outputs cleared immediately.
        @(negedge clk);
        in_valid = 1'b1;
        exp_a = 8'd120; mant_a = 23'h1; exp_b = 8'd100; mant_b = 23'h7F_FFFF;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (5) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_idle_zero("mid_shift_reset");
        repeat (2) @(negedge clk);
        check("reset_held_valid", longint'(out_valid), 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rerelease_in_ready", longint'(in_ready), 1);
        run_op(120, 1, 100, 'h7F_FFFF, 1);

        // Reset while DONE holds a result.
        @(negedge clk);
        in_valid = 1'b1;
        exp_a = 8'd50; mant_a = 23'h3; exp_b = 8'd50; mant_b = 23'h9;
        @(negedge clk);
        in_valid = 1'b0;
        k = 0;
        while (!out_valid && k < 20) begin
            @(negedge clk);
            k++;
        end
        check("pre_reset_done_valid", longint'(out_valid), 1);
        #2;
        rst_n = 1'b0;
        #1;
        check_idle_zero("mid_done_reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Random pairs; half with a small exponent gap to exercise short shifts.
        for (int n = 0; n < 60; n++) begin
            ea = int'($urandom_range(0, 255));
            if (n % 2 == 0) begin
                eb = ea + int'($urandom_range(0, 6)) - 3;
                if (eb < 0)   eb = 0;
                if (eb > 255) eb = 255;
            end else begin
                eb = int'($urandom_range(0, 255));
            end
            run_op(ea, int'($urandom_range(0, 'h7F_FFFF)), eb,
                   int'($urandom_range(0, 'h7F_FFFF)), int'($urandom_range(0, 3)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
